// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported, byte-addressed RAM between instruction fetch (IF)
// and the MEM-stage load/store path. One transaction runs at a time. Each
// transaction holds the RAM for MEM_LATENCY cycles and then spends one DONE
// cycle with the owner's valid pulse high. The data side has priority. After
// STARVE_LIMIT consecutive data grants made while a fetch was waiting, the
// fetch wins the next grant.
//
// Ports
//   clk, reset               rising-edge clock, asynchronous active-low reset
//   if_req/if_addr           fetch request, held until if_valid
//   if_rdata/if_valid        registered fetch word and one-cycle completion pulse
//   if_stall                 if_req & ~if_valid
//   mem_req/we/size/addr/wdata
//                            data request, held until mem_valid
//                            (size: 00 byte, 01 half, 10 word)
//   mem_rdata/mem_valid      registered load data and one-cycle completion pulse
//   mem_stall                mem_req & ~mem_valid
//   ram_en/rw/size/addr/wdata
//                            RAM command, driven only from the grant latches
//                            and forced to zero while ram_en is low
//   ram_rdata                RAM read data, sampled on the last busy cycle
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int MEM_LATENCY  = 2,  // 1..7
  parameter int STARVE_LIMIT = 3   // 1..15
) (
  input  logic        clk,
  input  logic        reset,
  // instruction fetch
  input  logic        if_req,
  input  logic [8:0]  if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  output logic        if_stall,
  // load/store
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [1:0]  mem_size,
  input  logic [8:0]  mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_valid,
  output logic        mem_stall,
  // RAM port
  output logic        ram_en,
  output logic        ram_rw,
  output logic [1:0]  ram_size,
  output logic [8:0]  ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY_IF,
    S_BUSY_MEM,
    S_DONE
  } state_t;

  localparam logic [2:0] LAT_LOAD   = 3'(MEM_LATENCY - 1);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [1:0] SIZE_WORD  = 2'b10;

  state_t      r_state;
  state_t      w_next_state;

  logic [2:0]  r_lat_cnt;     // busy cycles left after the current one
  logic [3:0]  r_starve_cnt;  // data grants issued while a fetch waited

  // Grant latches: the RAM port is driven only from these.
  logic        r_owner_if;
  logic        r_rw;
  logic [1:0]  r_size;
  logic [8:0]  r_addr;
  logic [31:0] r_wdata;

  logic [31:0] r_if_rdata;
  logic [31:0] r_mem_rdata;
  logic        r_if_valid;
  logic        r_mem_valid;

  logic        w_grant_if;
  logic        w_grant_mem;
  logic        w_busy;
  logic        w_last_busy;
  logic        w_starved;

  assign w_starved = (r_starve_cnt == STARVE_MAX);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge value of its inputs, independent of block evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // ---------------------------------------------------------------------------
  // Next state, grant decision, busy decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    w_next_state = r_state;
    w_grant_if   = 1'b0;
    w_grant_mem  = 1'b0;
    w_busy       = 1'b0;
    w_last_busy  = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        // Data wins unless a waiting fetch has already been passed over
        // STARVE_LIMIT times in a row.
        if (mem_req && !(if_req && w_starved)) begin
          w_grant_mem  = 1'b1;
          w_next_state = S_BUSY_MEM;
        end else if (if_req) begin
          w_grant_if   = 1'b1;
          w_next_state = S_BUSY_IF;
        end
      end
      S_BUSY_IF, S_BUSY_MEM: begin
        w_busy = 1'b1;
        if (r_lat_cnt == 3'd0) begin
          w_last_busy  = 1'b1;
          w_next_state = S_DONE;
        end
      end
      // One hold-off cycle with valid high: the requester deasserts or
      // changes its request here before the next grant is evaluated.
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Grant latches, counters, read-data return
  // ---------------------------------------------------------------------------
  // NOTE: the read-data and valid registers are reset because they are visible
  // outputs that must read 0 out of reset; the grant latches are reset too so
  // an aborted access leaves nothing behind.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lat_cnt    <= '0;
      r_starve_cnt <= '0;
      r_owner_if   <= 1'b0;
      r_rw         <= 1'b0;
      r_size       <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_if_rdata   <= '0;
      r_mem_rdata  <= '0;
      r_if_valid   <= 1'b0;
      r_mem_valid  <= 1'b0;
    end else begin
      if (w_grant_mem) begin
        r_owner_if <= 1'b0;
        r_rw       <= mem_we;
        r_size     <= mem_size;
        r_addr     <= mem_addr;
        r_wdata    <= mem_wdata;
        r_lat_cnt  <= LAT_LOAD;
      end else if (w_grant_if) begin
        r_owner_if <= 1'b1;
        r_rw       <= 1'b0;
        r_size     <= SIZE_WORD;
        r_addr     <= if_addr;
        r_wdata    <= '0;
        r_lat_cnt  <= LAT_LOAD;
      end else if (w_busy && !w_last_busy) begin
        r_lat_cnt <= r_lat_cnt - 3'd1;
      end

      // Count only data grants that actually made a fetch wait.
      if (w_grant_if) begin
        r_starve_cnt <= '0;
      end else if (w_grant_mem && if_req && !w_starved) begin
        r_starve_cnt <= r_starve_cnt + 4'd1;
      end

      r_if_valid  <= w_last_busy &  r_owner_if;
      r_mem_valid <= w_last_busy & ~r_owner_if;

      if (w_last_busy) begin
        if (r_owner_if) r_if_rdata  <= ram_rdata;
        else if (!r_rw) r_mem_rdata <= ram_rdata;  // stores keep old load data
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign if_rdata  = r_if_rdata;
  assign if_valid  = r_if_valid;
  assign mem_rdata = r_mem_rdata;
  assign mem_valid = r_mem_valid;

  // Gated by reset so that every output reads 0 while reset is held, even
  // with requests asserted.
  assign if_stall  = reset & if_req  & ~r_if_valid;
  assign mem_stall = reset & mem_req & ~r_mem_valid;

  assign ram_en    = w_busy;
  assign ram_rw    = w_busy & r_rw;
  assign ram_size  = w_busy ? r_size  : 2'b00;
  assign ram_addr  = w_busy ? r_addr  : 9'd0;
  assign ram_wdata = w_busy ? r_wdata : 32'd0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Bench for mem_port_arbiter with a byte-array RAM attached to the ram_* port.
// A transaction-level reference model tracks the grant edge of the current
// transaction and derives every output from its distance to that edge.
// Directed sequences pin the model with hand-computed values; a randomized
// phase then drives both requesters concurrently.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int L     = 2;
  localparam int LIMIT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [8:0]  if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        if_stall;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_size;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_valid;
  logic        mem_stall;
  logic        ram_en;
  logic        ram_rw;
  logic [1:0]  ram_size;
  logic [8:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  int checks = 0;
  int errors = 0;

  logic [7:0] ram_mem [512];  // the RAM the DUT talks to
  logic [7:0] ref_mem [512];  // the model's own view of memory

  mem_port_arbiter #(.MEM_LATENCY(L), .STARVE_LIMIT(LIMIT)) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_valid  (if_valid),
    .if_stall  (if_stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_size  (mem_size),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_valid (mem_valid),
    .mem_stall (mem_stall),
    .ram_en    (ram_en),
    .ram_rw    (ram_rw),
    .ram_size  (ram_size),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
    end
  endtask

  // Little-endian assembly of a byte/half/word, zero-extended.
  function automatic logic [31:0] pack(input logic [7:0] b0, input logic [7:0] b1,
                                       input logic [7:0] b2, input logic [7:0] b3,
                                       input logic [1:0] sz);
    case (sz)
      2'b00:   return {24'h0, b0};
      2'b01:   return {16'h0, b1, b0};
      default: return {b3, b2, b1, b0};
    endcase
  endfunction

  function automatic logic [31:0] ram_read(input logic [8:0] a, input logic [1:0] sz);
    return pack(ram_mem[a], ram_mem[a + 9'd1], ram_mem[a + 9'd2], ram_mem[a + 9'd3], sz);
  endfunction

  function automatic logic [31:0] ref_read(input logic [8:0] a, input logic [1:0] sz);
    return pack(ref_mem[a], ref_mem[a + 9'd1], ref_mem[a + 9'd2], ref_mem[a + 9'd3], sz);
  endfunction

  // ---------------------------------------------------------------------------
  // RAM: combinational read, write on each enabled clock edge
  // ---------------------------------------------------------------------------
  assign ram_rdata = ram_en ? ram_read(ram_addr, ram_size) : 32'h0;

  always @(posedge clk) begin
    if (ram_en && ram_rw) begin
      ram_mem[ram_addr] <= ram_wdata[7:0];
      if (ram_size != 2'b00) ram_mem[ram_addr + 9'd1] <= ram_wdata[15:8];
      if (ram_size == 2'b10) begin
        ram_mem[ram_addr + 9'd2] <= ram_wdata[23:16];
        ram_mem[ram_addr + 9'd3] <= ram_wdata[31:24];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model + per-cycle compare
  // A grant at edge g occupies the RAM for the L cycles after edges g..g+L-1,
  // the valid pulse follows edge g+L, and the next grant can occur at g+L+2.
  // ---------------------------------------------------------------------------
  typedef struct {
    bit          is_if;
    bit          we;
    logic [1:0]  size;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } txn_t;

  txn_t        m_cur;
  bit          m_have = 1'b0;
  int          m_g = 0;
  int          edge_n = 0;
  int          m_starve = 0;
  logic [31:0] m_if_rdata = '0;
  logic [31:0] m_mem_rdata = '0;
  bit          e_en, e_if_v, e_mem_v;
  int          m_d;

  always @(posedge clk) begin
    edge_n++;
    if (!reset) begin
      m_have      = 1'b0;
      m_starve    = 0;
      m_if_rdata  = '0;
      m_mem_rdata = '0;
    end else begin
      if (m_have && edge_n == m_g + L) begin
        if (m_cur.is_if)    m_if_rdata  = m_cur.rdata;
        else if (!m_cur.we) m_mem_rdata = m_cur.rdata;
      end
      if (!m_have || edge_n >= m_g + L + 2) begin
        if (mem_req && !(if_req && m_starve == LIMIT)) begin
          m_cur.is_if = 1'b0;
          m_cur.we    = mem_we;
          m_cur.size  = mem_size;
          m_cur.addr  = mem_addr;
          m_cur.wdata = mem_wdata;
          m_cur.rdata = ref_read(mem_addr, mem_size);
          if (mem_we) begin
            ref_mem[mem_addr] = mem_wdata[7:0];
            if (mem_size != 2'b00) ref_mem[mem_addr + 9'd1] = mem_wdata[15:8];
            if (mem_size == 2'b10) begin
              ref_mem[mem_addr + 9'd2] = mem_wdata[23:16];
              ref_mem[mem_addr + 9'd3] = mem_wdata[31:24];
            end
          end
          if (if_req && m_starve < LIMIT) m_starve++;
          m_have = 1'b1;
          m_g    = edge_n;
        end else if (if_req) begin
          m_cur.is_if = 1'b1;
          m_cur.we    = 1'b0;
          m_cur.size  = 2'b10;
          m_cur.addr  = if_addr;
          m_cur.wdata = '0;
          m_cur.rdata = ref_read(if_addr, 2'b10);
          m_starve    = 0;
          m_have      = 1'b1;
          m_g         = edge_n;
        end
      end
    end

    #1;
    m_d     = edge_n - m_g;
    e_en    = m_have && m_d >= 0 && m_d < L;
    e_if_v  = m_have &&  m_cur.is_if && m_d == L;
    e_mem_v = m_have && !m_cur.is_if && m_d == L;
    check("ram_en",    ram_en,    e_en);
    check("ram_rw",    ram_rw,    e_en && m_cur.we);
    check("ram_size",  ram_size,  e_en ? m_cur.size : 2'b00);
    check("ram_addr",  ram_addr,  e_en ? m_cur.addr : 9'd0);
    if (!e_en || m_cur.we) check("ram_wdata", ram_wdata, e_en ? m_cur.wdata : 32'd0);
    check("if_valid",  if_valid,  e_if_v);
    check("mem_valid", mem_valid, e_mem_v);
    check("if_rdata",  if_rdata,  m_if_rdata);
    check("mem_rdata", mem_rdata, m_mem_rdata);
    check("if_stall",  if_stall,  reset & if_req & ~e_if_v);
    check("mem_stall", mem_stall, reset & mem_req & ~e_mem_v);
  end

  // ---------------------------------------------------------------------------
  // Directed helpers
  // ---------------------------------------------------------------------------
  // Issue one data request, wait (bounded) for mem_valid, report the RAM
  // command seen on the first busy cycle.
  task automatic mem_op(input bit we, input logic [1:0] sz, input logic [8:0] a,
                        input logic [31:0] wd, output logic first_rw,
                        output logic [1:0] first_size);
    bit ok = 1'b0;
    bit seen = 1'b0;
    first_rw   = 1'b0;
    first_size = 2'b00;
    @(negedge clk);
    mem_req = 1'b1; mem_we = we; mem_size = sz; mem_addr = a; mem_wdata = wd;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ram_en && !seen) begin
        seen = 1'b1; first_rw = ram_rw; first_size = ram_size;
      end
      if (mem_valid) begin
        ok = 1'b1;
        break;
      end
    end
    mem_req = 1'b0;
    check("mem_op_done", ok, 1'b1);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic       rw_s;
  logic [1:0] sz_s;
  logic [7:0] seq;
  int         n_grant;
  int         cnt;
  bit         prev_en;

  initial begin
    reset = 1'b1;
    if_req = 1'b0; if_addr = '0;
    mem_req = 1'b0; mem_we = 1'b0; mem_size = '0; mem_addr = '0; mem_wdata = '0;
    for (int i = 0; i < 512; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      ram_mem[i] = b;
      ref_mem[i] = b;
    end
    #1 reset = 1'b0;

    // Reset held with random requests: every output stays 0.
    repeat (4) begin
      @(negedge clk);
      if_req = 1'($urandom); if_addr = 9'($urandom);
      mem_req = 1'($urandom); mem_we = 1'($urandom);
      mem_size = 2'($urandom_range(0, 2)); mem_addr = 9'($urandom);
      mem_wdata = $urandom;
    end
    if_req = 1'b1; mem_req = 1'b1;
    #1;
    check("rst_ram_en", {ram_en, ram_rw, ram_size, ram_addr}, '0);
    check("rst_stall",  {if_stall, mem_stall, if_valid, mem_valid}, '0);
    check("rst_rdata",  if_rdata | mem_rdata | ram_wdata, '0);

    // Release with no request: RAM stays idle for 10 cycles.
    @(negedge clk);
    if_req = 1'b0; mem_req = 1'b0;
    reset = 1'b1;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (ram_en) cnt++;
    end
    check("idle_no_en", cnt, 0);

    // IF read of 0x00A00093 at 0x010, then DONE hold-off with if_req kept high.
    ram_mem[9'h010] = 8'h93; ram_mem[9'h011] = 8'h00; ram_mem[9'h012] = 8'hA0; ram_mem[9'h013] = 8'h00;
    ref_mem[9'h010] = 8'h93; ref_mem[9'h011] = 8'h00; ref_mem[9'h012] = 8'hA0; ref_mem[9'h013] = 8'h00;
    @(negedge clk);
    if_req = 1'b1; if_addr = 9'h010;
    #1 check("if_stall_c0", if_stall, 1'b1);
    @(negedge clk);  // cycle 1
    check("if_c1", {ram_en, ram_addr, if_stall}, {1'b1, 9'h010, 1'b1});
    @(negedge clk);  // cycle 2
    check("if_c2", {ram_en, ram_addr, if_stall}, {1'b1, 9'h010, 1'b1});
    @(negedge clk);  // cycle 3
    check("if_c3_valid", {ram_en, if_valid, if_stall}, {1'b0, 1'b1, 1'b0});
    check("if_c3_rdata", if_rdata, 32'h00A00093);
    @(negedge clk);  // cycle 4: IDLE, no grant was made in the valid cycle
    check("holdoff_c4", {ram_en, if_valid}, 2'b00);
    @(negedge clk);  // cycle 5 = t+L+3
    check("holdoff_c5", ram_en, 1'b1);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (if_valid) begin
        cnt = 1;
        break;
      end
    end
    check("if2_done", cnt, 1);
    if_req = 1'b0;

    // Store then load.
    mem_op(1'b1, 2'b10, 9'h040, 32'hDEADBEEF, rw_s, sz_s);
    check("sw_ram_cmd", {rw_s, sz_s}, {1'b1, 2'b10});
    check("sw_rdata_kept", mem_rdata, 32'h0);
    mem_op(1'b0, 2'b10, 9'h040, 32'h0, rw_s, sz_s);
    check("lw_ram_cmd", {rw_s, sz_s}, {1'b0, 2'b10});
    check("lw_rdata", mem_rdata, 32'hDEADBEEF);
    mem_op(1'b0, 2'b00, 9'h041, 32'h0, rw_s, sz_s);
    check("lb_rdata", mem_rdata, 32'h000000BE);

    // Priority / starvation: both held high.
    @(negedge clk);
    if_req = 1'b1; if_addr = 9'h100;
    mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'b10; mem_addr = 9'h080;
    seq = '0; n_grant = 0; prev_en = 1'b0;
    for (int i = 0; i < 60 && n_grant < 8; i++) begin
      @(negedge clk);
      if (ram_en && !prev_en) begin
        seq[n_grant[2:0]] = (ram_addr == 9'h100);
        n_grant++;
      end
      prev_en = ram_en;
    end
    if_req = 1'b0; mem_req = 1'b0;
    check("grant_count", n_grant, 8);
    check("grant_seq", seq, 8'h88);
    repeat (6) @(negedge clk);

    // Reset in the first busy cycle of a load.
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'b10; mem_addr = 9'h020;
    @(posedge clk);
    #3 reset = 1'b0;
    #1 check("abort_en", {ram_en, mem_valid, mem_stall}, 3'b000);
    @(posedge clk);
    @(negedge clk);
    mem_req = 1'b0;
    reset = 1'b1;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (mem_valid || ram_en) cnt++;
    end
    check("abort_quiet", cnt, 0);
    mem_op(1'b0, 2'b10, 9'h040, 32'h0, rw_s, sz_s);
    check("abort_recover", mem_rdata, 32'hDEADBEEF);

    // Randomized concurrent traffic.
    fork
      begin
        for (int c = 0; c < 3000; c++) begin
          @(negedge clk);
          if (if_req && if_valid) if_req = 1'b0;
          if (!if_req && $urandom_range(0, 3) == 0) begin
            if_req = 1'b1; if_addr = 9'($urandom);
          end
        end
      end
      begin
        for (int c = 0; c < 3000; c++) begin
          @(negedge clk);
          if (mem_req && mem_valid) mem_req = 1'b0;
          if (!mem_req && $urandom_range(0, 2) == 0) begin
            mem_req = 1'b1; mem_we = 1'($urandom);
            mem_size = 2'($urandom_range(0, 2));
            mem_addr = 9'($urandom_range(0, 63));
            mem_wdata = $urandom;
          end
        end
      end
    join
    if_req = 1'b0; mem_req = 1'b0;
    repeat (8) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
